bit_serial_add_seq: RTL and testbench
=====================================

Name: bit_serial_add_seq

Overview:
- Bit-serial sequencer that sits directly upstream of the single-bit full-adder cell.
- Latches two WIDTH-bit operands and a carry-in, then feeds the cell one bit pair per cycle, LSB first.
- Feeds the registered carry back to the cell's carry input and shifts the cell's sum bits into a result register.
- Trades WIDTH cycles of latency for a single adder cell. Used where area matters more than throughput.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, 6, bit-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request pulse; operands sampled when accepted
- a_in  in  WIDTH  operand A
- b_in  in  WIDTH  operand B
- cy_in  in  1  carry-in for bit 0
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle pulse; sum_out/cy_out valid from this cycle
- sum_out  out  WIDTH  result, held until next accepted start
- cy_out  out  1  final carry, held with sum_out
- fa_a  out  1  to full-adder cell input a
- fa_b  out  1  to full-adder cell input b
- fa_cin  out  1  to full-adder cell carry input
- fa_sum  in  1  from full-adder cell sum
- fa_cout  in  1  from full-adder cell carry out

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-low (rst_n sampled on rising clk only).
- Reset values: all outputs and all internal registers are 0; state is IDLE.
- Registers:
  - a_sh, b_sh: operand shift registers.
  - s_sh: sum shift register.
  - c_r: carry register.
  - cnt: CNT_W-bit counter.
  - state: 2 bits.
- State IDLE (busy=0, done=0):
  - If start=1: a_sh<=a_in, b_sh<=b_in, c_r<=cy_in, cnt<=0, go to RUN.
- State RUN (busy=1):
  - Combinational outputs: fa_a=a_sh[0], fa_b=b_sh[0], fa_cin=c_r.
  - Each edge: a_sh and b_sh shift right by 1 (MSB fill 0); s_sh<={fa_sum, s_sh[WIDTH-1:1]}; c_r<=fa_cout; cnt<=cnt+1.
  - When cnt=WIDTH-1 at the edge: sum_out<={fa_sum, s_sh[WIDTH-1:1]}, cy_out<=fa_cout, go to DONE.
- State DONE (busy=0, done=1 for exactly one cycle):
  - If start=1, accept exactly as in IDLE and go to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- Outside RUN, fa_a/fa_b/fa_cin are driven 0.
- Latency: start sampled at the end of cycle 0; RUN occupies cycles 1..WIDTH; done=1 in cycle WIDTH+1. Throughput is one add per WIDTH+1 cycles.
- start while in RUN is ignored: no restart, no queuing, operands unaffected.
- sum_out/cy_out update only at the final RUN edge and are stable at all other times. They hold their old value while a new operation runs.
- Arithmetic: {cy_out, sum_out} = a_in + b_in + cy_in, computed modulo 2^(WIDTH+1).
- Reset mid-operation: rst_n=0 at any edge returns to IDLE and clears sum_out, cy_out, done and busy. No partial result is ever published.
- The full-adder cell is purely combinational, so fa_sum/fa_cout are consumed in the same cycle fa_a/fa_b/fa_cin are driven.

Optional Feature:
- Macro: BIT_SERIAL_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit), reset 0.
  - At the final RUN edge: ovf<=c_r ^ fa_cout, i.e. carry into MSB XOR carry out of MSB (two's-complement signed overflow).
  - ovf updates and holds alongside sum_out.
- When undefined: the ovf port and its logic are absent. All other behaviour is identical.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cy_in=0, start pulse → busy high cycles 1–8, done in cycle 9, sum_out=0x8D, cy_out=0 (ovf=1 if enabled).
- a=0xFF, b=0x01, cy_in=0 → sum_out=0x00, cy_out=1, ovf=0; a=0x7F, b=0x00, cy_in=1 → sum_out=0x80, cy_out=0, ovf=1.
- start held high and operands changed to 0x11/0x22 during RUN of 0x01+0x02 → result 0x03. New operands are accepted only when start is sampled in the DONE cycle, giving 0x33 done 9 cycles later.
- rst_n low for one cycle at cycle 4 of RUN → next cycle busy=0, done=0, sum_out=0x00, cy_out=0. No done pulse follows.
- Back-to-back: 0xAA+0x55 cy_in=1 then immediate start in DONE with 0x10+0x20 → first result 0x00/cy 1, second result 0x30/cy 0, done pulses 9 cycles apart.
- Monitor fa_a/fa_b/fa_cin each RUN cycle against the expected operand bits LSB-first and the running carry. Check they are 0 in IDLE/DONE.

Source files
------------

// File: rtl/bit_serial_add_seq.sv
// bit_serial_add_seq: bit-serial sequencer driving an external single-bit
// full-adder cell. Latches two WIDTH-bit operands plus carry-in. It then feeds
// one bit pair per cycle, LSB first, with the carry fed back through c_r.
// The finished sum and final carry are published in one update.
// Optional build macro: BIT_SERIAL_OVF_EN adds a signed-overflow output (ovf).
module bit_serial_add_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cy_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cy_out,
`ifdef BIT_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Only the upper WIDTH-1 sum bits need storage: the newest bit comes
    // straight from the cell, and the oldest bit would only be shifted out.
    logic [WIDTH-2:0] s_sh;
    logic             c_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] s_nxt;
    logic             last_bit;

    // Drive the cell only while bits are being processed.
    always_comb begin
        fa_a   = 1'b0;
        fa_b   = 1'b0;
        fa_cin = 1'b0;
        if (state == RUN) begin
            fa_a   = a_sh[0];
            fa_b   = b_sh[0];
            fa_cin = c_r;
        end
    end

    assign s_nxt    = {fa_sum, s_sh};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // Sequencer FSM: accept operands, step one bit per cycle, then publish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            s_sh    <= '0;
            c_r     <= 1'b0;
            cnt     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum_out <= '0;
            cy_out  <= 1'b0;
`ifdef BIT_SERIAL_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    // DONE accepts a new start exactly like IDLE, which gives
                    // back-to-back operation with no dead cycle.
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= a_in;
                        b_sh  <= b_in;
                        c_r   <= cy_in;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    // start is ignored here; operands already live in a_sh/b_sh.
                    a_sh <= a_sh >> 1;
                    b_sh <= b_sh >> 1;
                    s_sh <= s_nxt[WIDTH-1:1];
                    c_r  <= fa_cout;
                    cnt  <= cnt + 1'b1;
                    if (last_bit) begin
                        sum_out <= s_nxt;
                        cy_out  <= fa_cout;
`ifdef BIT_SERIAL_OVF_EN
                        // carry into MSB (c_r) vs carry out of MSB
                        ovf     <= c_r ^ fa_cout;
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_add_seq.sv
// Directed self-checking bench for bit_serial_add_seq (WIDTH=8).
// The full-adder cell is modelled combinationally next to the DUT.
module tb_bit_serial_add_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cy_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum_out;
    logic             cy_out;
    logic             ovf;
    logic             fa_a;
    logic             fa_b;
    logic             fa_cin;
    logic             fa_sum;
    logic             fa_cout;

    int errors = 0;
    int checks = 0;

    bit_serial_add_seq #(.WIDTH(WIDTH), .CNT_W(6)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .cy_in   (cy_in),
        .busy    (busy),
        .done    (done),
        .sum_out (sum_out),
        .cy_out  (cy_out),
`ifdef BIT_SERIAL_OVF_EN
        .ovf     (ovf),
`endif
        .fa_a    (fa_a),
        .fa_b    (fa_b),
        .fa_cin  (fa_cin),
        .fa_sum  (fa_sum),
        .fa_cout (fa_cout)
    );

`ifndef BIT_SERIAL_OVF_EN
    assign ovf = 1'b0;
`endif

    // Combinational full-adder cell.
    assign fa_sum  = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout = (fa_a & fa_b) | (fa_cin & (fa_a ^ fa_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one edge with the given operands.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic cy);
        @(negedge clk);
        a_in  = a;
        b_in  = b;
        cy_in = cy;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Walk the 8 RUN cycles checking busy, cell inputs and held result.
    task automatic check_run(input logic [7:0] a, input logic [7:0] b, input logic cy,
                             input logic [7:0] old_sum, input logic old_cy, input string nm);
        logic c;
        c = cy;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s run%0d busy/done: got %b/%b want 1/0", nm, i, busy, done);
            end
            checks++;
            if ({fa_a, fa_b, fa_cin} !== {a[i], b[i], c}) begin
                errors++;
                $display("FAIL %s run%0d fa a/b/cin: got %b%b%b want %b%b%b",
                         nm, i, fa_a, fa_b, fa_cin, a[i], b[i], c);
            end
            checks++;
            if (sum_out !== old_sum || cy_out !== old_cy) begin
                errors++;
                $display("FAIL %s run%0d held result: got %h/%b want %h/%b",
                         nm, i, sum_out, cy_out, old_sum, old_cy);
            end
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
    endtask

    // Check the DONE cycle (caller is positioned at the last RUN negedge).
    task automatic check_done(input logic [7:0] es, input logic ec, input logic eo, input string nm);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done cycle busy/done: got %b/%b want 0/1", nm, busy, done);
        end
        checks++;
        if (sum_out !== es || cy_out !== ec) begin
            errors++;
            $display("FAIL %s result: got %h/%b want %h/%b", nm, sum_out, cy_out, es, ec);
        end
`ifdef BIT_SERIAL_OVF_EN
        checks++;
        if (ovf !== eo) begin
            errors++;
            $display("FAIL %s ovf: got %b want %b", nm, ovf, eo);
        end
`else
        if (eo === 1'bx) $display("unreachable");
`endif
        checks++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            errors++;
            $display("FAIL %s fa in DONE: got %b%b%b want 000", nm, fa_a, fa_b, fa_cin);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cy_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, sum_out, cy_out, ovf} !== 12'h000) begin
            errors++;
            $display("FAIL reset outputs: got busy=%b done=%b sum=%h cy=%b ovf=%b want all 0",
                     busy, done, sum_out, cy_out, ovf);
        end
        checks++;
        if ({fa_a, fa_b, fa_cin} !== 3'b000) begin
            errors++;
            $display("FAIL reset fa: got %b%b%b want 000", fa_a, fa_b, fa_cin);
        end
    endtask

    task automatic test_add();
        start_op(8'h5A, 8'h33, 1'b0);
        check_run(8'h5A, 8'h33, 1'b0, 8'h00, 1'b0, "add_5a_33");
        check_done(8'h8D, 1'b0, 1'b1, "add_5a_33");
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || sum_out !== 8'h8D) begin
            errors++;
            $display("FAIL idle_after_done: got busy=%b done=%b sum=%h want 0/0/8d",
                     busy, done, sum_out);
        end
        start_op(8'hFF, 8'h01, 1'b0);
        check_run(8'hFF, 8'h01, 1'b0, 8'h8D, 1'b0, "add_ff_01");
        check_done(8'h00, 1'b1, 1'b0, "add_ff_01");
        start_op(8'h7F, 8'h00, 1'b1);
        check_run(8'h7F, 8'h00, 1'b1, 8'h00, 1'b1, "add_7f_00_c");
        check_done(8'h80, 1'b0, 1'b1, "add_7f_00_c");
    endtask

    task automatic test_start_held();
        @(negedge clk);
        a_in  = 8'h01;
        b_in  = 8'h02;
        cy_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        a_in = 8'h11;
        b_in = 8'h22;
        check_run(8'h01, 8'h02, 1'b0, 8'h80, 1'b0, "held_first");
        check_done(8'h03, 1'b0, 1'b0, "held_first");
        check_run(8'h11, 8'h22, 1'b0, 8'h03, 1'b0, "held_second");
        check_done(8'h33, 1'b0, 1'b0, "held_second");
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL held_release: got busy=%b done=%b want 0/0", busy, done);
        end
    endtask

    task automatic test_back_to_back();
        start_op(8'hAA, 8'h55, 1'b1);
        check_run(8'hAA, 8'h55, 1'b1, 8'h33, 1'b0, "b2b_first");
        check_done(8'h00, 1'b1, 1'b0, "b2b_first");
        a_in  = 8'h10;
        b_in  = 8'h20;
        cy_in = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check_run(8'h10, 8'h20, 1'b0, 8'h00, 1'b1, "b2b_second");
        check_done(8'h30, 1'b0, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_mid();
        int seen_done;
        start_op(8'h5A, 8'h33, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, sum_out, cy_out} !== 11'h000) begin
            errors++;
            $display("FAIL reset_mid outputs: got busy=%b done=%b sum=%h cy=%b want 0",
                     busy, done, sum_out, cy_out);
        end
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen_done++;
        end
        checks++;
        if (seen_done !== 0) begin
            errors++;
            $display("FAIL reset_mid no_done: got %0d active cycles want 0", seen_done);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_start_held();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
